dmem_burst_ctrl: RTL and testbench

Burst access controller that drives the single-port `datamemory` (6-bit word address, 32-bit data, `ce`/`we` strobes) on behalf of a host. It accepts one command at a time (start address, beat count, direction), sequences the memory strobes, streams write data in, and streams read data out with valid/last flags. It sits between the datapath/host and `datamemory`, and is the only block that drives the memory's control pins.

---
 rtl/dmem_burst_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dmem_burst_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_burst_ctrl.sv
// dmem_burst_ctrl: burst sequencer in front of the single-port datamemory.
// Streams write beats into memory and returns read words with valid/last flags.
module dmem_burst_ctrl #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   // Handshakes: a transfer happens on an edge where valid && ready are both 1;
   // rd_valid has no ready and is presented for exactly one cycle per beat.
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              done,
   output logic              mem_ce,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_dataIn,
   input  logic [DATA_W-1:0] mem_dataOut
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_WFIN  = 3'd2,
      S_READ  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] cur;
   logic [ADDR_W-1:0] cur_nxt;
   logic [LEN_W-1:0]  cnt;
   logic [LEN_W-1:0]  cnt_nxt;
   logic              mem_ce_nxt;
   logic              mem_we_nxt;
   logic [ADDR_W-1:0] mem_address_nxt;
   logic [DATA_W-1:0] mem_data_in_nxt;
   logic              issue_last;
   logic              issue_last_nxt;
   logic              done_nxt;
   logic              pipe_valid;
   logic              pipe_last;
   logic              cmd_fire;
   logic              wr_fire;
   logic              read_issue;
   logic              last_beat;

   assign cmd_ready  = (state == S_IDLE);
   assign wr_ready   = (state == S_WRITE);
   assign cmd_fire   = cmd_valid && cmd_ready;
   assign wr_fire    = wr_valid && wr_ready;
   assign last_beat  = (cnt == '0);
   // A read is on the memory pins whenever ce is set without we.
   assign read_issue = mem_ce && !mem_we;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (cmd_fire) state_nxt = cmd_write ? S_WRITE : S_READ;
         S_WRITE: if (wr_fire && last_beat) state_nxt = S_WFIN;
         S_WFIN:  state_nxt = S_IDLE;
         S_READ:  if (last_beat) state_nxt = S_DRAIN;
         S_DRAIN: if (pipe_last) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cur_nxt         = cur;
      cnt_nxt         = cnt;
      mem_ce_nxt      = 1'b0;
      mem_we_nxt      = 1'b0;
      mem_address_nxt = mem_address;
      mem_data_in_nxt = mem_dataIn;
      issue_last_nxt  = 1'b0;
      done_nxt        = 1'b0;
      case (state)
         S_IDLE: begin
            if (cmd_fire) begin
               cur_nxt = cmd_addr;
               cnt_nxt = cmd_len;
            end
         end
         S_WRITE: begin
            if (wr_fire) begin
               mem_ce_nxt      = 1'b1;
               mem_we_nxt      = 1'b1;
               mem_address_nxt = cur;
               mem_data_in_nxt = wr_data;
               cur_nxt         = cur + ADDR_ONE;
               cnt_nxt         = cnt - LEN_ONE;
            end
         end
         S_WFIN: begin
            done_nxt = 1'b1;
         end
         S_READ: begin
            mem_ce_nxt      = 1'b1;
            mem_address_nxt = cur;
            cur_nxt         = cur + ADDR_ONE;
            cnt_nxt         = cnt - LEN_ONE;
            issue_last_nxt  = last_beat;
         end
         S_DRAIN: begin
            // The final beat leaves the return pipe on this edge.
            done_nxt = pipe_last;
         end
         default: begin
            done_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur         <= '0;
         cnt         <= '0;
         mem_ce      <= 1'b0;
         mem_we      <= 1'b0;
         mem_address <= '0;
         mem_dataIn  <= '0;
         issue_last  <= 1'b0;
         pipe_valid  <= 1'b0;
         pipe_last   <= 1'b0;
         rd_valid    <= 1'b0;
         rd_last     <= 1'b0;
         rd_data     <= '0;
         done        <= 1'b0;
      end else begin
         cur         <= cur_nxt;
         cnt         <= cnt_nxt;
         mem_ce      <= mem_ce_nxt;
         mem_we      <= mem_we_nxt;
         mem_address <= mem_address_nxt;
         mem_dataIn  <= mem_data_in_nxt;
         issue_last  <= issue_last_nxt;
         // Stage 1 marks the edge the memory drives dataOut; stage 2 captures it.
         pipe_valid  <= read_issue;
         pipe_last   <= read_issue && issue_last;
         rd_valid    <= pipe_valid;
         rd_last     <= pipe_last;
         if (pipe_valid) begin
            rd_data <= mem_dataOut;
         end
         done        <= done_nxt;
      end
   end

endmodule

// File: tb/tb_dmem_burst_ctrl.sv
// tb_dmem_burst_ctrl: directed plus randomized bursts against a word-array
// reference of memory contents and cycle-exact timing expectations.
module tb_dmem_burst_ctrl;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 6;
   localparam int DEPTH  = 64;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic              cmd_write = 1'b0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [LEN_W-1:0]  cmd_len = '0;
   logic              wr_valid = 1'b0;
   logic              wr_ready;
   logic [DATA_W-1:0] wr_data = '0;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_last;
   logic              done;
   logic              mem_ce;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_dataIn;
   logic [DATA_W-1:0] mem_dataOut = '0;

   logic [DATA_W-1:0] mem_arr [DEPTH];
   logic [DATA_W-1:0] ref_mem [DEPTH];
   logic [DATA_W-1:0] exp_q [$];
   logic [DATA_W-1:0] wdata_q [$];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dmem_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .done(done),
      .mem_ce(mem_ce), .mem_we(mem_we), .mem_address(mem_address),
      .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
   );

   // Behaviour of the external datamemory: synchronous write and registered read.
   always @(posedge clk) begin
      if (mem_ce) begin
         if (mem_we) mem_arr[mem_address] <= mem_dataIn;
         else        mem_dataOut <= mem_arr[mem_address];
      end
   end

   task automatic check_bit(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
      end
   endtask

   task automatic check_word(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_idle(input string tag);
      check_bit({tag, "_ce"}, mem_ce, 1'b0);
      check_bit({tag, "_we"}, mem_we, 1'b0);
      check_word({tag, "_addr"}, DATA_W'(mem_address), '0);
      check_word({tag, "_din"}, mem_dataIn, '0);
      check_bit({tag, "_rd_valid"}, rd_valid, 1'b0);
      check_bit({tag, "_rd_last"}, rd_last, 1'b0);
      check_word({tag, "_rd_data"}, rd_data, '0);
      check_bit({tag, "_done"}, done, 1'b0);
      check_bit({tag, "_cmd_ready"}, cmd_ready, 1'b1);
      check_bit({tag, "_wr_ready"}, wr_ready, 1'b0);
   endtask

   task automatic check_mem();
      for (int i = 0; i < DEPTH; i++)
         check_word($sformatf("mem_word_%0d", i), mem_arr[i], ref_mem[i]);
   endtask

   task automatic issue_cmd(input bit write, input int addr, input int len);
      check_bit("cmd_ready_before_cmd", cmd_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd_write = write;
      cmd_addr  = ADDR_W'(addr);
      cmd_len   = LEN_W'(len);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
      cmd_len   = LEN_W'($urandom_range(0, DEPTH - 1));
      check_bit("cmd_ready_after_accept", cmd_ready, 1'b0);
   endtask

   // gap < 0 picks a random 0..2 idle cycles between beats.
   task automatic do_write(input int addr, input int len, input int gap);
      int a;
      int g;
      issue_cmd(1'b1, addr, len);
      check_bit("wr_ready_after_accept", wr_ready, 1'b1);
      for (int i = 0; i <= len; i++) begin
         if (i > 0) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int j = 0; j < g; j++) begin
               wr_valid = 1'b0;
               @(negedge clk);
               check_bit("wr_gap_ce", mem_ce, 1'b0);
               check_bit("wr_gap_we", mem_we, 1'b0);
               check_bit("wr_gap_done", done, 1'b0);
            end
         end
         wr_valid = 1'b1;
         wr_data  = wdata_q[i];
         @(negedge clk);
         wr_valid = 1'b0;
         wr_data  = $urandom;
         a = (addr + i) % DEPTH;
         check_bit("wr_beat_ce", mem_ce, 1'b1);
         check_bit("wr_beat_we", mem_we, 1'b1);
         check_word("wr_beat_addr", DATA_W'(mem_address), DATA_W'(a));
         check_word("wr_beat_din", mem_dataIn, wdata_q[i]);
         check_bit("wr_beat_done", done, 1'b0);
         check_bit("wr_beat_ready", wr_ready, logic'(i < len));
         ref_mem[a] = wdata_q[i];
      end
      @(negedge clk);
      check_bit("wr_done_pulse", done, 1'b1);
      check_bit("wr_done_ce", mem_ce, 1'b0);
      check_bit("wr_done_cmd_ready", cmd_ready, 1'b1);
      check_bit("wr_done_wr_ready", wr_ready, 1'b0);
      @(negedge clk);
      check_bit("wr_done_single", done, 1'b0);
   endtask

   // poke offers a write command while the read is busy; it must be ignored.
   task automatic do_read(input int addr, input int len, input bit poke);
      logic exp_v;
      logic [DATA_W-1:0] expd;
      exp_q.delete();
      for (int i = 0; i <= len; i++) exp_q.push_back(ref_mem[(addr + i) % DEPTH]);
      issue_cmd(1'b0, addr, len);
      for (int k = 1; k <= len + 4; k++) begin
         if (poke && k == 1) begin
            cmd_valid = 1'b1;
            cmd_write = 1'b1;
            cmd_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
            cmd_len   = LEN_W'($urandom_range(0, 3));
            wr_valid  = 1'b1;
            wr_data   = $urandom;
         end
         if (poke && k == 2) begin
            cmd_valid = 1'b0;
            wr_valid  = 1'b0;
         end
         @(negedge clk);
         if (k <= len + 1) begin
            check_bit("rd_issue_ce", mem_ce, 1'b1);
            check_bit("rd_issue_we", mem_we, 1'b0);
            check_word("rd_issue_addr", DATA_W'(mem_address), DATA_W'((addr + k - 1) % DEPTH));
         end else begin
            check_bit("rd_tail_ce", mem_ce, 1'b0);
         end
         exp_v = (k >= 3) && (k <= len + 3);
         check_bit("rd_valid", rd_valid, exp_v);
         if (exp_v) begin
            expd = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check_word("rd_data", rd_data, expd);
         end
         check_bit("rd_last", rd_last, logic'(k == len + 3));
         check_bit("rd_done", done, logic'(k == len + 3));
         check_bit("rd_cmd_ready", cmd_ready, logic'(k >= len + 3));
      end
      check_word("rd_beats_left", DATA_W'(exp_q.size()), '0);
   endtask

   task automatic do_read_reset(input int addr, input int len);
      issue_cmd(1'b0, addr, len);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_idle("rst_mid");
      rst_n = 1'b1;
      for (int k = 0; k < len + 4; k++) begin
         @(negedge clk);
         check_bit("rst_after_rd_valid", rd_valid, 1'b0);
         check_bit("rst_after_done", done, 1'b0);
         check_bit("rst_after_ce", mem_ce, 1'b0);
      end
      check_bit("rst_after_cmd_ready", cmd_ready, 1'b1);
   endtask

   task automatic fill_random(input int len);
      wdata_q.delete();
      for (int i = 0; i <= len; i++) wdata_q.push_back($urandom);
   endtask

   initial begin
      int ra;
      int rl;
      for (int i = 0; i < DEPTH; i++) begin
         mem_arr[i] = '0;
         ref_mem[i] = '0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("post_reset");

      wdata_q = '{32'd15, 32'd16, 32'd17, 32'd18};
      do_write(10, 3, 0);
      check_mem();
      do_read(10, 3, 1'b0);

      fill_random(1);
      do_write(30, 1, 3);
      check_mem();
      do_read(30, 1, 1'b0);

      fill_random(2);
      do_write(62, 2, -1);
      check_mem();
      do_read(62, 2, 1'b0);

      wdata_q.delete();
      for (int i = 0; i < DEPTH; i++) wdata_q.push_back(DATA_W'(i + 100));
      do_write(0, 63, 0);
      check_mem();
      do_read(0, 63, 1'b0);

      do_read(5, 0, 1'b0);

      do_read_reset(20, 7);
      check_mem();
      do_read(20, 7, 1'b0);

      do_read(40, 5, 1'b1);
      check_mem();

      for (int n = 0; n < 6; n++) begin
         ra = int'($urandom_range(0, DEPTH - 1));
         rl = int'($urandom_range(0, 15));
         fill_random(rl);
         do_write(ra, rl, -1);
         check_mem();
         ra = int'($urandom_range(0, DEPTH - 1));
         rl = int'($urandom_range(0, 20));
         do_read(ra, rl, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
